// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned MEM_BYTES  = 64;
  localparam int unsigned NUM_PORTS  = 2;
  localparam int unsigned BYTE_OFF_W = 3;

  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: the port not served last wins a tie.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant_c
);

  always_comb begin
    o_grant_c = 2'b00;
    case (i_req)
      2'b01:   o_grant_c = 2'b01;
      2'b10:   o_grant_c = 2'b10;
      2'b11:   o_grant_c = (i_last == PORT_DBG) ? 2'b01 : 2'b10;
      default: o_grant_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with an IDLE/ACCESS/RESP access sequencer.
// Optional feature macro: DMEM_ARB_ALIGN_CHECK_EN (reject misaligned accesses).
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] memAdd,
  output logic [DATA_W-1:0] writeData,
  output logic              memWrite,
  output logic              memRead,
  input  logic [DATA_W-1:0] readData
);

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_last;
  logic                   r_port;
  logic [NUM_PORTS-1:0]   r_rsp_valid;
  logic [DATA_W-1:0]      r_rsp_rdata;
  logic [ADDR_W-1:0]      r_mem_add;
  logic [DATA_W-1:0]      r_write_data;
  logic                   r_mem_write;
  logic                   r_mem_read;

  logic [NUM_PORTS-1:0]   w_grant;
  logic [NUM_PORTS-1:0]   w_req_ready;
  logic                   w_accept;
  logic                   w_acc_port;
  logic                   w_acc_write;
  logic [ADDR_W-1:0]      w_acc_addr;
  logic [DATA_W-1:0]      w_acc_wdata;
  logic                   w_aligned;
  logic                   w_rsp_ready;
  logic                   w_rsp_done;

  rr_arbiter2 u_arb (
    .i_req     ({req1_valid, req0_valid}),
    .i_last    (r_last),
    .o_grant_c (w_grant)
  );

  assign w_accept    = |w_req_ready;
  assign w_acc_port  = w_req_ready[1];
  assign w_acc_write = w_acc_port ? req1_write : req0_write;
  assign w_acc_addr  = w_acc_port ? req1_addr  : req0_addr;
  assign w_acc_wdata = w_acc_port ? req1_wdata : req0_wdata;
  assign w_rsp_ready = (r_port == PORT_DBG) ? rsp1_ready : rsp0_ready;
  assign w_rsp_done  = (r_state == RESP) && w_rsp_ready;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic r_skip;
  logic r_rsp_err;
  assign w_aligned = (w_acc_addr[BYTE_OFF_W-1:0] == BYTE_OFF_W'(0));
  assign rsp0_err  = r_rsp_err;
  assign rsp1_err  = r_rsp_err;
`else
  assign w_aligned = 1'b1;
  assign rsp0_err  = 1'b0;
  assign rsp1_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Ready is only offered to the arbitration winner while idle and out of reset.
  always_comb begin
    w_next_state = r_state;
    w_req_ready  = '0;
    case (r_state)
      IDLE: begin
        w_req_ready = reset ? 2'b00 : w_grant;
        if (|w_req_ready) w_next_state = ACCESS;
      end
      ACCESS:  w_next_state = RESP;
      RESP:    if (w_rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Strobes are set on accept so they are high for exactly the ACCESS cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last       <= PORT_DBG;
      r_port       <= PORT_LSU;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_mem_add    <= '0;
      r_write_data <= '0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      r_skip       <= 1'b0;
      r_rsp_err    <= 1'b0;
`endif
    end else begin
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      if (w_accept) begin
        r_port      <= w_acc_port;
        r_mem_add   <= w_acc_addr;
        r_mem_write <= w_acc_write && w_aligned;
        r_mem_read  <= !w_acc_write && w_aligned;
        if (w_acc_write) r_write_data <= w_acc_wdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        r_skip      <= !w_aligned;
`endif
      end
      if (r_state == ACCESS) begin
        r_rsp_valid <= (r_port == PORT_DBG) ? 2'b10 : 2'b01;
        r_rsp_rdata <= r_mem_read ? readData : '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        r_rsp_err   <= r_skip;
`endif
      end
      if (w_rsp_done) begin
        r_rsp_valid <= '0;
        r_last      <= r_port;
      end
    end
  end

  assign req0_ready = w_req_ready[0];
  assign req1_ready = w_req_ready[1];
  assign rsp0_valid = r_rsp_valid[0];
  assign rsp1_valid = r_rsp_valid[1];
  assign rsp0_rdata = r_rsp_rdata;
  assign rsp1_rdata = r_rsp_rdata;
  assign memAdd     = r_mem_add;
  assign writeData  = r_write_data;
  assign memWrite   = r_mem_write;
  assign memRead    = r_mem_read;

endmodule
